// File: rtl/rr_request_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin request arbiter.
package rr_request_arbiter4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Index of the set bit in a one-hot (or zero) vector; zero maps to index 0.
  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    onehot_idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) onehot_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/rr_request_arbiter4_if.sv
// Request/grant bundle between the request sources (master) and the arbiter (slave).
interface rr_request_arbiter4_if;
  // Handshake: req[k] is a level held by requester k until it is served. gnt is
  // a registered one-hot that stays high while the grantee keeps req[k] high and
  // has not pulsed done. done counts only in the grant's own cycles. After every
  // grant gnt is zero for at least one cycle.
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout_err;
  logic [1:0] ptr;

  modport master (
    output req, done,
    input  gnt, gnt_valid, timeout_err, ptr
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, timeout_err, ptr
  );
endinterface

// File: rtl/rr_request_arbiter4_pick4.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo 4.
module rr_pick4
  import rr_request_arbiter4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] sel_onehot,
  output logic       any
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    sel_onehot = 4'b0000;
    found      = 1'b0;
    idx        = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        sel_onehot[idx] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_request_arbiter4.sv
// Round-robin arbiter for four requesters, with a bounded hold time and a
// registered one-hot grant.
module rr_request_arbiter4
  import rr_request_arbiter4_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rr_request_arbiter4_if.slave  bus,
  output arb_state_t            dbg_state_o
);

  arb_state_t    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  logic [3:0]    sel_onehot;
  logic          any_req;
  logic [1:0]    g_idx;
  logic          early_rel;
  logic          tmo_hit;

  rr_pick4 u_pick (
    .req        (bus.req),
    .ptr        (ptr_q),
    .sel_onehot (sel_onehot),
    .any        (any_req)
  );

  assign g_idx     = onehot_idx(gnt_q);
  assign early_rel = bus.done | ~bus.req[g_idx];
  assign tmo_hit   = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (any_req) begin
          gnt_d   = sel_onehot;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (early_rel || tmo_hit) begin
          gnt_d   = 4'b0000;
          ptr_d   = g_idx + 2'd1;
          state_d = ST_IDLE;
          // A cooperative release takes precedence over a coincident timeout.
          terr_d  = tmo_hit & ~early_rel;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_valid   = |gnt_q;
  assign bus.timeout_err = terr_q;
  assign bus.ptr         = ptr_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_rr_request_arbiter4.sv
// Directed vector bench for rr_request_arbiter4 (TIMEOUT=16).
module tb_rr_request_arbiter4;
  import rr_request_arbiter4_pkg::*;

  localparam int NVEC = 27;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       terr;
    logic [1:0] ptr;
  } vec_t;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  int         checks;
  int         failures;
  vec_t       vecs [NVEC];

  rr_request_arbiter4_if bus ();

  rr_request_arbiter4 #(.TIMEOUT(16), .CW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard helpers
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string nm, input logic [3:0] eg, input logic et,
                            input logic [1:0] ep);
    check({nm, ".gnt"}, 8'(bus.gnt), 8'(eg));
    check({nm, ".gnt_valid"}, 8'(bus.gnt_valid), 8'(|eg));
    check({nm, ".timeout_err"}, 8'(bus.timeout_err), 8'(et));
    check({nm, ".ptr"}, 8'(bus.ptr), 8'(ep));
    check({nm, ".state"}, 8'(dbg_state), 8'((eg != 4'b0000) ? ST_GRANT : ST_IDLE));
    check({nm, ".onehot0"}, 8'($onehot0(bus.gnt)), 8'd1);
  endtask

  // Driver tasks
  task automatic drive(input logic [3:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
  endtask

  task automatic step(input string nm, input logic [3:0] eg, input logic et,
                      input logic [1:0] ep);
    @(posedge clk);
    #1;
    check_outs(nm, eg, et, ep);
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs("reset", 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1 check_outs("reset_hold", 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vectors(input string nm, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].req, vecs[i].done);
      step($sformatf("%s[%0d]", nm, i), vecs[i].gnt, vecs[i].terr, vecs[i].ptr);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // req=0101, done three cycles into each grant; ptr walks 0,1,3,1.
    vecs[0]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0};
    vecs[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0};
    vecs[2]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd0};
    vecs[3]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[4]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 2'd1};
    vecs[5]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 2'd1};
    vecs[6]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 2'd1};
    vecs[7]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 2'd3};
    vecs[8]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd3};
    vecs[9]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd3};
    vecs[10] = '{4'b0101, 1'b0, 4'b0001, 1'b0, 2'd3};
    vecs[11] = '{4'b0101, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
    // req=1111 with done held high: full rotation with one-cycle gaps.
    vecs[14] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    vecs[15] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd1};
    vecs[16] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd1};
    vecs[17] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[18] = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd2};
    vecs[19] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3};
    vecs[20] = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd3};
    vecs[21] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[22] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    // Grantee drops its request with no done.
    vecs[23] = '{4'b1110, 1'b0, 4'b0000, 1'b0, 2'd1};
    vecs[24] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1};
    vecs[25] = '{4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1};
    vecs[26] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2};

    do_reset();
    run_vectors("alt", 0, 13);

    do_reset();
    run_vectors("all", 14, 22);
    run_vectors("drop", 23, 26);

    // Async reset mid-grant while ptr is non-zero.
    drive(4'b0100, 1'b0);
    step("ar_grant", 4'b0100, 1'b0, 2'd2);
    step("ar_hold", 4'b0100, 1'b0, 2'd2);
    #2 rst_n = 1'b0;
    #1 check_outs("ar_async", 4'b0000, 1'b0, 2'd0);
    @(posedge clk);
    #1 check_outs("ar_low", 4'b0000, 1'b0, 2'd0);
    #3 rst_n = 1'b1;
    step("ar_regrant", 4'b0100, 1'b0, 2'd0);

    // Pure timeout: sixteen cycles of grant, then a single error pulse.
    do_reset();
    drive(4'b1000, 1'b0);
    for (int i = 0; i < 16; i++) step($sformatf("tmo_hold%0d", i), 4'b1000, 1'b0, 2'd0);
    step("tmo_release", 4'b0000, 1'b1, 2'd0);
    drive(4'b0000, 1'b0);
    step("tmo_after", 4'b0000, 1'b0, 2'd0);

    // done coincident with the last permitted cycle: normal release, no error.
    do_reset();
    drive(4'b0010, 1'b0);
    for (int i = 0; i < 16; i++) step($sformatf("col_hold%0d", i), 4'b0010, 1'b0, 2'd1 - 2'd1);
    drive(4'b0010, 1'b1);
    step("col_release", 4'b0000, 1'b0, 2'd2);
    drive(4'b0000, 1'b0);
    step("col_after", 4'b0000, 1'b0, 2'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_request_arbiter4.md
Name: rr_request_arbiter4

Overview:
- Round-robin arbiter for four request lines. Produces a registered one-hot grant that feeds directly into the 4-to-2 encoder stage, so the encoder always sees zero or exactly one active input.
- Holds each grant until the grantee signals done, drops its request, or a timeout expires.
- Sits between raw request sources and the encoder/index path.

Parameters:
- TIMEOUT, 16, maximum cycles a grant may be held; legal range 1..255.
- CW, 8, width of the internal hold counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit k is requester k; level-sensitive.
- done  input  1  single-cycle pulse from the current grantee ending its grant.
- gnt  output  4  registered one-hot grant, or 4'b0000.
- gnt_valid  output  1  high when gnt is non-zero; equals the OR of gnt.
- timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.
- ptr  output  2  current round-robin priority pointer (debug/observability).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-grant), taking effect immediately without waiting for clk:
  - gnt=0, gnt_valid=0, timeout_err=0, ptr=0.
  - FSM=IDLE, hold counter=0.
- FSM states are IDLE and GRANT.
- IDLE:
  - If req != 0, select the first set bit searching upward from ptr with wrap: ptr, ptr+1, ..., mod 4.
  - On the next edge, gnt = one-hot of the selected index, the counter is cleared, and the FSM goes to GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req == 0, stay in IDLE with gnt=0.
- GRANT, with g = the granted index:
  - Release occurs on done=1, or req[g]=0, or counter == TIMEOUT-1.
  - On release, the next edge gives gnt=0, ptr=(g+1) mod 4, and the FSM goes to IDLE.
  - Otherwise the counter increments and gnt holds.
  - A grant therefore lasts at most TIMEOUT cycles.
- Timeout:
  - timeout_err=1 for exactly one cycle, coincident with the cycle gnt first reads 0.
  - It fires only when the release cause is timeout alone.
  - If done or req[g]=0 coincides with the timeout condition, it is a normal release with no error.
- Mandatory gap: at least one cycle of gnt=0 between any two grants, including back-to-back requests by different requesters.
- Requests by non-grantees during GRANT are ignored and are not latched. Arbitration uses req as sampled in IDLE.
- done while in IDLE is ignored.
- ptr changes only on release, never on grant.
- A requester that holds req high after release gets lowest priority at the next arbitration, until the others are served.
- gnt_valid is derived combinationally from the gnt register, with no extra latency.
- Pointer wraps 3 -> 0.
- Counter saturation is impossible by construction, because release occurs at TIMEOUT-1.
- Invariant: gnt is never multi-hot.

Decomposition:
- Shared header (arb_defs.vh):
  - State encodings: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Requester count define (4).
- One natural sub-module: rr_pick4, purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: sel_onehot[3:0], any.
  - The top module holds the FSM, counter, ptr and output registers.

Test Plan:
- Reset, then req=4'b0101 held with done pulsed 3 cycles after each grant:
  - Expected sequence: gnt=0001, 0000 (gap), 0100, 0000, 0001.
  - Expected ptr values: 0, 1, 3, 1.
- Single request, TIMEOUT=16: req=4'b1000, no done:
  - gnt=1000 for exactly 16 cycles.
  - Then gnt=0000 with timeout_err=1 for 1 cycle; ptr=0.
- req=4'b1111 with immediate done each grant:
  - Grant order 0001, 0010, 0100, 1000, 0001, each separated by a 1-cycle gap.
  - gnt is never multi-hot.
- Grantee drop: gnt=0010, then req[1] falls with no done:
  - Next cycle gnt=0000, ptr=2, timeout_err=0.
- Collision: done asserted in the same cycle the counter reaches TIMEOUT-1:
  - gnt releases and timeout_err stays 0.
- Async reset: rst_n pulled low mid-grant (gnt=0100), between clock edges:
  - gnt=0, ptr=0 immediately, before the next clk edge.
  - After rst_n rises with req=4'b0100, gnt=0100 one cycle later.
